// File: rtl/dlx_control_param.sv
// dlx_control_param: multi-cycle DLX control unit covering instruction fetch,
// decode, word load/store and halt, with an optional branch extension.
//
// Optional feature macro: DLX_CTRL_BRANCH_EN
//   defined   -> BEQZ (000100) and J (000010) execute through the BRANCH state
//   undefined -> both opcodes decode as illegal and halt the machine
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   step_en, run_mode    single-step request / free-running enable
//   busy                 memory busy; a transfer completes when mr|mw=1 and busy=0
//   data_in              instruction fetch data
//   gpr_rdata_a          register file read data for gpr_raddr_a
//   mr, mw               registered memory read / write strobes
//   memory_address       fetch address (FETCH) or effective address (otherwise)
//   gpr_raddr_a/_b       rs / rt fields of the instruction register
//   gpr_we, gpr_waddr    register write strobe (load completion) and address
//   pc, sm_state         program counter and state encoding
//   halted, illegal      sticky halt and illegal-opcode flags
module dlx_control_param #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic              run_mode,
  input  logic              busy,
  input  logic [31:0]       data_in,
  input  logic [31:0]       gpr_rdata_a,
  output logic              mr,
  output logic              mw,
  output logic [ADDR_W-1:0] memory_address,
  output logic [4:0]        gpr_raddr_a,
  output logic [4:0]        gpr_raddr_b,
  output logic              gpr_we,
  output logic [4:0]        gpr_waddr,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        sm_state,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned INSN_W = 32;
  localparam int unsigned OPC_W  = 6;

  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;
`ifdef DLX_CTRL_BRANCH_EN
  localparam logic [OPC_W-1:0] OP_BEQZ = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
`endif

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_LOAD      = 4'd3,
    ST_STORE     = 4'd4,
    ST_WRITEBACK = 4'd5,
    ST_BRANCH    = 4'd6,
    ST_HALT      = 4'd7
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSN_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                mr_q, mr_d;
  logic                mw_q, mw_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  logic [OPC_W-1:0]    opcode;
  logic [31:0]         imm_sext;

  assign opcode   = ir_q[31:26];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

`ifdef DLX_CTRL_BRANCH_EN
  logic [31:0]         jmp_sext;
  assign jmp_sext = {{6{ir_q[25]}}, ir_q[25:0]};
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ea_d      = ea_q;
    mr_d      = mr_q;
    mw_d      = mw_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_INIT: begin
        if (step_en || run_mode) begin
          state_d = ST_FETCH;
          mr_d    = 1'b1;
        end
      end

      ST_FETCH: begin
        if (!busy) begin
          ir_d    = data_in;
          pc_d    = pc_q + PC_W'(1);
          mr_d    = 1'b0;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ea_d = ADDR_W'(gpr_rdata_a + imm_sext);
        case (opcode)
          OP_LW: begin
            state_d = ST_LOAD;
            mr_d    = 1'b1;
          end
          OP_SW: begin
            state_d = ST_STORE;
            mw_d    = 1'b1;
          end
          OP_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
`ifdef DLX_CTRL_BRANCH_EN
          OP_BEQZ, OP_J: begin
            state_d = ST_BRANCH;
          end
`endif
          default: begin
            state_d   = ST_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end

      ST_LOAD, ST_STORE: begin
        if (!busy) begin
          mr_d    = 1'b0;
          mw_d    = 1'b0;
          state_d = ST_WRITEBACK;
        end
      end

      // Free-running skips INIT; single-step waits for step_en to drop
      ST_WRITEBACK: begin
        if (run_mode) begin
          state_d = ST_FETCH;
          mr_d    = 1'b1;
        end else if (!step_en) begin
          state_d = ST_INIT;
        end
      end

`ifdef DLX_CTRL_BRANCH_EN
      // pc already points past the branch, offsets are relative to that
      ST_BRANCH: begin
        if (opcode == OP_BEQZ) begin
          if (gpr_rdata_a == 32'd0) begin
            pc_d = pc_q + PC_W'(imm_sext);
          end
        end else begin
          pc_d = pc_q + PC_W'(jmp_sext);
        end
        state_d = ST_WRITEBACK;
      end
`endif

      ST_HALT: begin
        mr_d     = 1'b0;
        mw_d     = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      pc_q      <= '0;
      ir_q      <= '0;
      ea_q      <= '0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ea_q      <= ea_d;
      mr_q      <= mr_d;
      mw_q      <= mw_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Address mux: pc during fetch, effective address everywhere else
  always_comb begin
    memory_address = ea_q;
    if (state_q == ST_FETCH) begin
      memory_address = ADDR_W'(pc_q);
    end
  end

  assign gpr_raddr_a = ir_q[25:21];
  assign gpr_raddr_b = ir_q[20:16];
  assign gpr_waddr   = ir_q[20:16];
  assign gpr_we      = (state_q == ST_LOAD) && !busy && (ir_q[20:16] != 5'd0);

  assign mr       = mr_q;
  assign mw       = mw_q;
  assign pc       = pc_q;
  assign sm_state = 4'(state_q);
  assign halted   = halted_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_dlx_control_param.sv
// Directed bench for dlx_control_param (PC_W=4, ADDR_W=16) with a simple
// word-addressed memory responder that holds busy for busy_lat cycles.
module tb_dlx_control_param;

  localparam int unsigned PC_W   = 4;
  localparam int unsigned ADDR_W = 16;

  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD = 4'd3;
  localparam logic [3:0] S_WB = 4'd5;
  localparam logic [3:0] S_HALT = 4'd7;

  logic              clk;
  logic              reset;
  logic              step_en;
  logic              run_mode;
  logic              busy;
  logic [31:0]       data_in;
  logic [31:0]       rdata_a;
  logic              mr;
  logic              mw;
  logic [ADDR_W-1:0] memory_address;
  logic [4:0]        gpr_raddr_a;
  logic [4:0]        gpr_raddr_b;
  logic              gpr_we;
  logic [4:0]        gpr_waddr;
  logic [PC_W-1:0]   pc;
  logic [3:0]        sm_state;
  logic              halted;
  logic              illegal;

  logic [31:0] mem [0:255];
  int busy_lat = 0;
  int bcnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int we_cnt = 0;
  int both_cnt = 0;
  logic [4:0] last_waddr = 5'd0;

  int total = 0;
  int bad = 0;

  dlx_control_param #(.PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .step_en        (step_en),
    .run_mode       (run_mode),
    .busy           (busy),
    .data_in        (data_in),
    .gpr_rdata_a    (rdata_a),
    .mr             (mr),
    .mw             (mw),
    .memory_address (memory_address),
    .gpr_raddr_a    (gpr_raddr_a),
    .gpr_raddr_b    (gpr_raddr_b),
    .gpr_we         (gpr_we),
    .gpr_waddr      (gpr_waddr),
    .pc             (pc),
    .sm_state       (sm_state),
    .halted         (halted),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_in = mem[memory_address[7:0]];
  assign busy    = (mr | mw) && (bcnt < busy_lat);

  // Memory latency counter and transfer / write-strobe bookkeeping
  always @(posedge clk) begin
    if ((mr | mw) && busy) bcnt <= bcnt + 1;
    else                   bcnt <= 0;
    if (mr && !busy) rd_cnt <= rd_cnt + 1;
    if (mw && !busy) wr_cnt <= wr_cnt + 1;
    if (mr && mw)    both_cnt <= both_cnt + 1;
    if (gpr_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= gpr_waddr;
    end
  end

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    step_en  = 1'b0;
    run_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max) begin
      @(negedge clk);
      if (sm_state == s) ok = 1'b1;
      n++;
    end
  endtask

  task automatic do_step(output bit ok);
    bit ok1;
    bit ok2;
    step_en = 1'b1;
    wait_state(S_WB, 60, ok1);
    step_en = 1'b0;
    wait_state(S_INIT, 10, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    step_en  = 1'b1;
    run_mode = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sm_state !== S_INIT) begin bad++; $display("FAIL reset_state: got %0d want 0", sm_state); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    total++; if (mr !== 1'b0 || mw !== 1'b0) begin bad++; $display("FAIL reset_strobes: got mr=%0b mw=%0b want 0 0", mr, mw); end
    total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags: got halted=%0b illegal=%0b want 0 0", halted, illegal); end
    total++; if (gpr_we !== 1'b0) begin bad++; $display("FAIL reset_gpr_we: got %0b want 0", gpr_we); end
    total++; if (memory_address !== 16'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", memory_address); end
    do_reset();
  endtask

  task automatic test_step_lw;
    bit ok;
    int rd0;
    int we0;
    clear_mem();
    mem[0]   = 32'h8C23_0004;  // LW r3,4(r1)
    mem[12]  = 32'hDEAD_BEEF;
    rdata_a  = 32'd8;
    busy_lat = 2;
    do_reset();
    rd0 = rd_cnt;
    we0 = we_cnt;
    step_en = 1'b1;
    wait_state(S_WB, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL step_reach_wb: got timeout want WRITEBACK"); end
    total++; if (memory_address !== 16'd12) begin bad++; $display("FAIL step_ea: got %0d want 12", memory_address); end
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL step_we_pulses: got %0d want 1", we_cnt - we0); end
    total++; if (last_waddr !== 5'd3) begin bad++; $display("FAIL step_waddr: got %0d want 3", last_waddr); end
    total++; if (pc !== 4'd1) begin bad++; $display("FAIL step_pc: got %0d want 1", pc); end
    total++; if (rd_cnt - rd0 !== 2) begin bad++; $display("FAIL step_reads: got %0d want 2", rd_cnt - rd0); end
    repeat (3) @(negedge clk);
    total++; if (sm_state !== S_WB) begin bad++; $display("FAIL step_hold_wb: got %0d want 5", sm_state); end
    step_en = 1'b0;
    @(negedge clk);
    total++; if (sm_state !== S_INIT) begin bad++; $display("FAIL step_to_init: got %0d want 0", sm_state); end
    repeat (3) @(negedge clk);
    total++; if (pc !== 4'd1 || sm_state !== S_INIT) begin bad++; $display("FAIL step_single: got pc=%0d state=%0d want 1 0", pc, sm_state); end
  endtask

  task automatic test_run_mode;
    bit ok;
    int rd0;
    int wr0;
    int we0;
    clear_mem();
    mem[0]   = 32'hAC22_0000;  // SW r2,0(r1)
    mem[1]   = 32'h8C24_0000;  // LW r4,0(r1)
    mem[2]   = 32'hFC00_0000;  // HALT
    rdata_a  = 32'd40;
    busy_lat = 1;
    do_reset();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    we0 = we_cnt;
    run_mode = 1'b1;
    wait_state(S_HALT, 100, ok);
    run_mode = 1'b0;
    @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL run_reach_halt: got timeout want HALT"); end
    total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL run_writes: got %0d want 1", wr_cnt - wr0); end
    total++; if (rd_cnt - rd0 !== 4) begin bad++; $display("FAIL run_reads: got %0d want 4", rd_cnt - rd0); end
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL run_we: got %0d want 1", we_cnt - we0); end
    total++; if (halted !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL run_flags: got halted=%0b illegal=%0b want 1 0", halted, illegal); end
    total++; if (pc !== 4'd3) begin bad++; $display("FAIL run_pc: got %0d want 3", pc); end
    total++; if (mr !== 1'b0 || mw !== 1'b0) begin bad++; $display("FAIL run_halt_strobes: got mr=%0b mw=%0b want 0 0", mr, mw); end
  endtask

  task automatic test_illegal;
    bit ok;
    int rd0;
    clear_mem();
    mem[0]   = 32'h0400_0000;  // opcode 000001
    rdata_a  = 32'd0;
    busy_lat = 0;
    do_reset();
    step_en = 1'b1;
    wait_state(S_HALT, 40, ok);
    step_en = 1'b0;
    @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL ill_reach_halt: got timeout want HALT"); end
    total++; if (illegal !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL ill_flags: got illegal=%0b halted=%0b want 1 1", illegal, halted); end
    rd0 = rd_cnt;
    for (int k = 0; k < 3; k++) begin
      step_en = 1'b1;
      repeat (2) @(negedge clk);
      step_en = 1'b0;
      @(negedge clk);
    end
    run_mode = 1'b1;
    repeat (4) @(negedge clk);
    run_mode = 1'b0;
    @(negedge clk);
    total++; if (sm_state !== S_HALT) begin bad++; $display("FAIL ill_sticky_state: got %0d want 7", sm_state); end
    total++; if (pc !== 4'd1) begin bad++; $display("FAIL ill_sticky_pc: got %0d want 1", pc); end
    total++; if (rd_cnt - rd0 !== 0 || mr !== 1'b0) begin bad++; $display("FAIL ill_no_access: got reads=%0d mr=%0b want 0 0", rd_cnt - rd0, mr); end
  endtask

  task automatic test_pc_wrap;
    bit ok;
    int n;
    int we0;
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h8C20_0000;  // LW r0,0(r1)
    rdata_a  = 32'd100;
    busy_lat = 0;
    do_reset();
    we0 = we_cnt;
    run_mode = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (pc == 4'd15) ok = 1'b1;
      n++;
    end
    total++; if (!ok) begin bad++; $display("FAIL wrap_reach_15: got timeout want pc=15"); end
    wait_state(S_FETCH, 10, ok);
    if (ok) wait_state(S_DECODE, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_reach_decode: got timeout want DECODE"); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL wrap_pc: got %0d want 0", pc); end
    run_mode = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL wrap_r0_we: got %0d want 0", we_cnt - we0); end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    clear_mem();
    mem[0]   = 32'h8C23_0004;
    rdata_a  = 32'd8;
    busy_lat = 20;
    do_reset();
    step_en = 1'b1;
    wait_state(S_LOAD, 60, ok);
    total++; if (!ok || mr !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_in_load: got ok=%0b mr=%0b busy=%0b want 1 1 1", ok, mr, busy); end
    reset = 1'b1;
    #1;
    total++; if (mr !== 1'b0 || mw !== 1'b0) begin bad++; $display("FAIL mid_strobe_drop: got mr=%0b mw=%0b want 0 0", mr, mw); end
    total++; if (sm_state !== S_INIT || pc !== 4'd0) begin bad++; $display("FAIL mid_state_pc: got state=%0d pc=%0d want 0 0", sm_state, pc); end
    step_en  = 1'b0;
    busy_lat = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branch;
    bit ok;
    bit ok2;
`ifdef DLX_CTRL_BRANCH_EN
    clear_mem();
    mem[0]   = 32'h0800_0004;  // J +4
    mem[5]   = 32'h1020_FFFD;  // BEQZ r1,-3
    busy_lat = 0;
    rdata_a  = 32'd0;
    do_reset();
    do_step(ok);
    total++; if (!ok || pc !== 4'd5) begin bad++; $display("FAIL br_jump: got ok=%0b pc=%0d want 1 5", ok, pc); end
    do_step(ok);
    total++; if (!ok || pc !== 4'd3) begin bad++; $display("FAIL br_beqz_taken: got ok=%0b pc=%0d want 1 3", ok, pc); end
    rdata_a = 32'd1;
    do_reset();
    do_step(ok);
    do_step(ok2);
    total++; if (!ok || !ok2 || pc !== 4'd6 || illegal !== 1'b0) begin bad++; $display("FAIL br_beqz_not_taken: got pc=%0d illegal=%0b want 6 0", pc, illegal); end
`else
    clear_mem();
    mem[0]   = 32'h1020_FFFD;  // BEQZ r1,-3
    busy_lat = 0;
    rdata_a  = 32'd0;
    do_reset();
    step_en = 1'b1;
    wait_state(S_HALT, 40, ok);
    step_en = 1'b0;
    total++; if (!ok || illegal !== 1'b1) begin bad++; $display("FAIL nobr_beqz_illegal: got ok=%0b illegal=%0b want 1 1", ok, illegal); end
    mem[0] = 32'h0800_0004;  // J +4
    do_reset();
    step_en = 1'b1;
    wait_state(S_HALT, 40, ok2);
    step_en = 1'b0;
    total++; if (!ok2 || illegal !== 1'b1 || pc !== 4'd1) begin bad++; $display("FAIL nobr_j_illegal: got ok=%0b illegal=%0b pc=%0d want 1 1 1", ok2, illegal, pc); end
`endif
    do_reset();
  endtask

  initial begin
    reset    = 1'b1;
    step_en  = 1'b0;
    run_mode = 1'b0;
    rdata_a  = 32'd0;
    clear_mem();
    test_reset();
    test_step_lw();
    test_run_mode();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_load();
    test_branch();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d overlap cycles want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
